// File: rtl/ar_r_channel_pkg.sv
// Shared definitions for the SRAM-to-AXI bridge: port IDs, fixed AXI3 AR fields,
// and the read-address FSM state type. The write-channel block imports this too.
package ar_r_channel_pkg;

  localparam logic [3:0] INST_ID  = 4'd0;
  localparam logic [3:0] DATA_ID  = 4'd1;
  localparam int         INST_IDX = 0;
  localparam int         DATA_IDX = 1;
  localparam int         NUM_PORTS = 2;

  // Every bridge transaction is a single beat, incrementing, normal access.
  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'b0000;
  localparam logic [2:0] AXI_PROT  = 3'b000;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  function automatic logic [2:0] ar_size_of(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/ar_r_resp_reg.sv
// Per-port read-return register: tracks the port's single outstanding read,
// captures its R data and pulses data_ok the cycle after the final beat.
module ar_r_resp_reg #(
  parameter logic [3:0] PORT_ID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_pending,
  input  logic        r_fire,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  output logic        pending,
  output logic        data_ok,
  output logic [31:0] port_rdata
);

  logic        pending_reg;
  logic        data_ok_reg;
  logic [31:0] rdata_reg;
  logic        hit;

  // Beats for another ID, or for a port with nothing outstanding, are dropped.
  assign hit = r_fire & pending_reg & (rid == PORT_ID);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      data_ok_reg <= 1'b0;
      rdata_reg   <= 32'd0;
    end else begin
      data_ok_reg <= hit;
      if (hit) begin
        rdata_reg   <= rdata;
        pending_reg <= 1'b0;
      end else if (set_pending) begin
        pending_reg <= 1'b1;
      end
    end
  end

  assign pending    = pending_reg;
  assign data_ok    = data_ok_reg;
  assign port_rdata = rdata_reg;

endmodule

// File: rtl/ar_r_channel.sv
// Read half of the SRAM-to-AXI bridge: arbitrates inst/data read requests onto
// single-beat AXI3 AR transactions and routes R data back by ID.
module ar_r_channel (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        wr_busy,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  import ar_r_channel_pkg::*;

  ar_state_t   state_reg, state_next;
  logic [31:0] araddr_reg;
  logic [3:0]  arid_reg;
  logic [2:0]  arsize_reg;

  logic        grant_data, grant_inst;
  logic        data_elig, inst_elig;
  logic        ar_fire, r_fire;

  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] set_pending;
  logic [NUM_PORTS-1:0] data_ok_vec;
  logic [31:0]          rdata_vec [NUM_PORTS];

  // Error responses are not reported back to the SRAM ports.
  logic unused_rresp;
  assign unused_rresp = ^rresp;

  // Data reads must not overtake a write still in flight on the write channel.
  assign data_elig = data_sram_req & ~data_sram_wr & ~pending[DATA_IDX] & ~wr_busy;
  assign inst_elig = inst_sram_req & ~inst_sram_wr & ~pending[INST_IDX];

  always_comb begin
    state_next = state_reg;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    case (state_reg)
      AR_IDLE: begin
        if (!reset) begin
          if (data_elig) begin
            grant_data = 1'b1;
          end else if (inst_elig) begin
            grant_inst = 1'b1;
          end
          if (grant_data || grant_inst) begin
            state_next = AR_SEND;
          end
        end
      end
      AR_SEND: begin
        if (arready) begin
          state_next = AR_IDLE;
        end
      end
      default: state_next = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= AR_IDLE;
      araddr_reg <= 32'd0;
      arid_reg   <= 4'd0;
      arsize_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (grant_data) begin
        araddr_reg <= data_sram_addr;
        arid_reg   <= DATA_ID;
        arsize_reg <= ar_size_of(data_sram_size);
      end else if (grant_inst) begin
        araddr_reg <= inst_sram_addr;
        arid_reg   <= INST_ID;
        arsize_reg <= ar_size_of(inst_sram_size);
      end
    end
  end

  assign ar_fire = (state_reg == AR_SEND) & arready;
  assign rready  = |pending;
  assign r_fire  = rvalid & rready & rlast;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
      assign set_pending[gi] = ar_fire & (arid_reg == 4'(gi));

      ar_r_resp_reg #(
        .PORT_ID(4'(gi))
      ) u_resp (
        .clk        (clk),
        .reset      (reset),
        .set_pending(set_pending[gi]),
        .r_fire     (r_fire),
        .rid        (rid),
        .rdata      (rdata),
        .pending    (pending[gi]),
        .data_ok    (data_ok_vec[gi]),
        .port_rdata (rdata_vec[gi])
      );
    end
  endgenerate

  assign inst_sram_addr_ok = grant_inst;
  assign data_sram_addr_ok = grant_data;
  assign inst_sram_data_ok = data_ok_vec[INST_IDX];
  assign data_sram_data_ok = data_ok_vec[DATA_IDX];
  assign inst_sram_rdata   = rdata_vec[INST_IDX];
  assign data_sram_rdata   = rdata_vec[DATA_IDX];

  assign arvalid = (state_reg == AR_SEND);
  assign araddr  = araddr_reg;
  assign arid    = arid_reg;
  assign arsize  = arsize_reg;
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;

endmodule

// File: doc/ar_r_channel.md
# ar_r_channel

Read half of the SRAM-to-AXI bridge: accepts read requests from the instruction and data SRAM-like ports, issues single-beat AXI3 read-address transactions, and returns read data to the requesting port. It sits beside the write-address/write-data channel block and shares the AXI master interface with it; the write block owns AW/W, this block owns AR/R.

## Interface
Parameters: none; all widths fixed by the 32-bit AXI3 bus.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inst_sram_req / data_sram_req  in  1  read request valid
- inst_sram_wr / data_sram_wr  in  1  write flag; requests with wr=1 are never accepted here
- inst_sram_size / data_sram_size  in  2  log2 bytes (0/1/2)
- inst_sram_addr / data_sram_addr  in  32  byte address
- inst_sram_addr_ok / data_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok / data_sram_data_ok  out  1  one-cycle pulse, rdata valid
- inst_sram_rdata / data_sram_rdata  out  32  returned data
- wr_busy  in  1  write channel has unacknowledged writes; blocks data reads
- arid  out  4  0 = inst, 1 = data
- araddr  out  32; arlen  out  8 (0); arsize  out  3 ({0,size}); arburst  out  2 (01); arlock  out  2 (0); arcache  out  4 (0); arprot  out  3 (0)
- arvalid  out  1; arready  in  1
- rid  in  4; rdata  in  32; rresp  in  2 (ignored); rlast  in  1; rvalid  in  1; rready  out  1

## Operation
- AR FSM, two states: IDLE, AR_SEND.
- IDLE: a port is eligible when req=1, wr=0, its outstanding flag is 0; data additionally needs wr_busy=0. Data has priority over inst. Granted port sees addr_ok=1 (combinational); araddr/arid/arsize registered; go to AR_SEND.
- AR_SEND: arvalid=1, AR fields held stable; on arready set outstanding[arid], return to IDLE. No acceptance while in AR_SEND.
- Max one outstanding read per port, two total; R beats may return in either order.
- rready = outstanding[0] | outstanding[1].
- R handshake with rlast=1 and rid in {0,1} with flag set: clear that flag, register rdata into that port's rdata register, pulse that port's data_ok next cycle.
- R beats with unknown rid or clear flag: consumed, no data_ok, no state change.
- rresp not checked; rlast=0 beats do not occur (arlen=0) and are ignored.

## Timing
- Reset values: arvalid=0, araddr=0, arid=0, arsize=0, rready=0, both addr_ok=0, both data_ok=0, both rdata=0, outstanding=00, FSM=IDLE.
- Reset mid-transaction drops all in-flight state; arvalid low the cycle after reset asserts; late R beats after reset are ignored (rready=0).
- Accept at cycle T, arvalid from T+1, arready at T+1 -> earliest R at T+2, data_ok at T+3. Back-to-back accept at T+2.
- Same-cycle R completion and new request on same port: flag still set at T, request accepted earliest next cycle.
- Both ports' R completions in consecutive cycles give data_ok in consecutive cycles; rdata holds until overwritten by that port's next return.
- wr_busy sampled only in IDLE; rising after acceptance does not cancel AR.

## Structure
- Shared bridge package: ID constants (INST_ID=0, DATA_ID=1), fixed AXI fields (len, burst, lock, cache, prot), AR FSM state enum; the write-channel block reuses the package.
- One sub-module natural: ar_r_resp_reg, per-port return register (flag clear, rdata capture, data_ok pulse), instantiated twice.

## Test plan
- Single inst read 0x1FC0_0000 size 2, arready immediate, rdata 0xDEAD_BEEF rid 0 -> arid 0, arsize 010, inst data_ok pulse T+3 with 0xDEAD_BEEF.
- Both req same cycle -> data granted first (arid 1), inst accepted two cycles later; R returned inst-first -> data_ok on correct ports, correct data.
- wr_busy=1 with data req -> data_addr_ok stays 0 and inst still served; wr_busy drops -> data accepted next cycle.
- arready held low 5 cycles -> arvalid and araddr stable, no addr_ok for either port until arready.
- Stray R beat rid 3 and rid 0 with no outstanding -> consumed, no data_ok.
- reset asserted in AR_SEND -> arvalid 0 next cycle, outstanding cleared, later R beat produces no data_ok.
